// File: rtl/window_reader.sv
// 3x3 window front end: captures a raster pixel stream into four rotating line
// stores and replays three resident lines as packed 3x3 windows.
module window_reader #(
    parameter int LINE_WIDTH = 256,
    parameter int PIX_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pixel_in,
    input  logic               pixel_in_valid,
    output logic               pixel_in_ready,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] window_out,
    output logic               window_valid,
    output logic               line_done
);

    localparam int CW = $clog2(LINE_WIDTH);
    localparam int FW = $clog2(4 * LINE_WIDTH) + 1;

    localparam logic [FW-1:0] FILL_CAP    = FW'(4 * LINE_WIDTH);
    localparam logic [FW-1:0] FILL_THRESH = FW'(3 * LINE_WIDTH);
    localparam logic [FW-1:0] FILL_LINE   = FW'(LINE_WIDTH);
    localparam logic [CW-1:0] LAST_FETCH  = CW'(LINE_WIDTH - 3);
    localparam logic [CW-1:0] LAST_WR_COL = CW'(LINE_WIDTH - 1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t         state;
    logic [PIX_W-1:0] store [4*LINE_WIDTH];
    logic [1:0]     wr_sel;
    logic [1:0]     rd_sel;
    logic [CW-1:0]  wr_col;
    logic [CW-1:0]  rd_col;
    logic [FW-1:0]  fill_count;
    logic [FW-1:0]  fill_next;

    logic           wr_fire;
    logic           fetch;
    logic           pass_end;
    logic [1:0]     sel1;
    logic [1:0]     sel2;
    logic [CW-1:0]  col1;
    logic [CW-1:0]  col2;
    logic [9*PIX_W-1:0] window_next;

    assign pixel_in_ready = (fill_count < FILL_CAP);
    assign wr_fire        = pixel_in_valid && pixel_in_ready;
    assign fetch          = (state == READ) && out_ready;
    assign pass_end       = fetch && (rd_col == LAST_FETCH);

    assign sel1 = rd_sel + 2'd1;
    assign sel2 = rd_sel + 2'd2;
    assign col1 = rd_col + CW'(1);
    assign col2 = rd_col + CW'(2);

    // Top line lands in the most significant row; leftmost column leads each row.
    assign window_next = {
        store[{rd_sel, rd_col}], store[{rd_sel, col1}], store[{rd_sel, col2}],
        store[{sel1,   rd_col}], store[{sel1,   col1}], store[{sel1,   col2}],
        store[{sel2,   rd_col}], store[{sel2,   col1}], store[{sel2,   col2}]
    };

    always_comb begin
        fill_next = fill_count;
        if (wr_fire) begin
            fill_next = fill_next + FW'(1);
        end
        if (pass_end) begin
            fill_next = fill_next - FILL_LINE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            store[{wr_sel, wr_col}] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_sel       <= '0;
            rd_sel       <= '0;
            wr_col       <= '0;
            rd_col       <= '0;
            fill_count   <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            line_done    <= 1'b0;
        end else begin
            fill_count   <= fill_next;
            window_valid <= fetch;
            line_done    <= pass_end;

            if (wr_fire) begin
                wr_col <= wr_col + CW'(1);
                if (wr_col == LAST_WR_COL) begin
                    wr_sel <= wr_sel + 2'd1;
                end
            end

            // Threshold is re-checked only from IDLE, so passes are separated by one idle cycle.
            case (state)
                IDLE: begin
                    if (fill_count >= FILL_THRESH) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (fetch) begin
                        window_out <= window_next;
                        if (pass_end) begin
                            rd_col <= '0;
                            rd_sel <= rd_sel + 2'd1;
                            state  <= IDLE;
                        end else begin
                            rd_col <= rd_col + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_reader.sv
// Self-checking bench for window_reader: every cycle is compared against a
// pixel-history reference model that derives windows from absolute line numbers.
module tb_window_reader;

    localparam int LW = 8;
    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic [PW-1:0] pixel_in;
    logic          pixel_in_valid;
    logic          pixel_in_ready;
    logic          out_ready;
    logic [9*PW-1:0] window_out;
    logic          window_valid;
    logic          line_done;

    int total;
    int bad;

    bit [7:0]  acc[$];
    int        passes;
    int        m_res;
    int        m_col;
    bit        m_reading;
    bit        exp_valid;
    bit        exp_done;
    logic [71:0] exp_win;

    int          win_cnt;
    int          done_cnt;
    logic [71:0] first_win;
    logic [71:0] last_win;

    window_reader #(.LINE_WIDTH(LW), .PIX_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in_ready (pixel_in_ready),
        .out_ready      (out_ready),
        .window_out     (window_out),
        .window_valid   (window_valid),
        .line_done      (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Window k, column c: rows are absolute lines k, k+1, k+2 of the accepted stream.
    function automatic logic [71:0] model_window(input int k, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                w = (w << 8) | 72'(acc[(k + r) * LW + c + j]);
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        acc.delete();
        passes    = 0;
        m_res     = 0;
        m_col     = 0;
        m_reading = 1'b0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_win   = '0;
    endtask

    task automatic model_step(input bit v, input bit [7:0] p, input bit o);
        bit wf;
        bit fe;
        bit st;
        wf = v && (m_res < 4 * LW);
        fe = m_reading && o;
        st = !m_reading && (m_res >= 3 * LW);
        exp_valid = fe;
        exp_done  = 1'b0;
        if (fe) begin
            exp_win = model_window(passes, m_col);
            if (m_col == LW - 3) begin
                exp_done  = 1'b1;
                passes++;
                m_col     = 0;
                m_reading = 1'b0;
                m_res     = m_res - LW;
            end else begin
                m_col++;
            end
        end
        if (st) m_reading = 1'b1;
        if (wf) begin
            acc.push_back(p);
            m_res++;
        end
    endtask

    task automatic clear_counts();
        win_cnt   = 0;
        done_cnt  = 0;
        first_win = '0;
        last_win  = '0;
    endtask

    // One clock cycle: drive, check ready, advance model, then check registered outputs.
    task automatic applyStimulus(input bit v, input bit [7:0] p, input bit o, input bit r);
        rst            = r;
        pixel_in_valid = v;
        pixel_in       = p;
        out_ready      = o;
        checkOutput("ready", 72'(pixel_in_ready), 72'(m_res < 4 * LW));
        if (r) model_reset();
        else   model_step(v, p, o);
        @(posedge clk);
        #1;
        checkOutput("valid", 72'(window_valid), 72'(exp_valid));
        checkOutput("done",  72'(line_done), 72'(exp_done));
        checkOutput("window", window_out, exp_win);
        checkOutput("fill", 72'(dut.fill_count), 72'(m_res));
        if (window_valid === 1'b1) begin
            if (win_cnt == 0) first_win = window_out;
            last_win = window_out;
            win_cnt++;
        end
        if (line_done === 1'b1) done_cnt++;
    endtask

    task automatic basic_stream(input bit toggle_ready);
        clear_counts();
        for (int i = 0; i < 3 * LW; i++) applyStimulus(1'b1, 8'(i), toggle_ready ? 1'(i % 2 == 0) : 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, toggle_ready ? 1'(i % 2 == 0) : 1'b1, 1'b0);
        checkOutput("basic_windows", 72'(win_cnt), 72'd6);
        checkOutput("basic_first", first_win, 72'h000102_08090a_101112);
        checkOutput("basic_last", last_win, 72'h050607_0d0e0f_151617);
        checkOutput("basic_done", 72'(done_cnt), 72'd1);
        checkOutput("basic_fill", 72'(dut.fill_count), 72'd16);
    endtask

    initial begin
        int guard;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        pixel_in = '0;
        out_ready = 1'b0;
        model_reset();
        clear_counts();
        @(posedge clk);
        #1;

        $display("[TB] reset state");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rst_ready", 72'(pixel_in_ready), 72'd1);
        checkOutput("rst_window", window_out, 72'd0);

        $display("[TB] basic pass");
        basic_stream(1'b0);

        $display("[TB] full and backpressure");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 5 * LW; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        checkOutput("full_ready", 72'(pixel_in_ready), 72'd0);
        checkOutput("full_fill", 72'(dut.fill_count), 72'd32);
        checkOutput("full_windows", 72'(win_cnt), 72'd0);
        for (int i = 0; i < LW - 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain_windows", 72'(win_cnt), 72'd6);
        checkOutput("drain_ready", 72'(pixel_in_ready), 72'd1);
        checkOutput("drain_last", last_win, 72'h454647_4d4e4f_555657);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] stall mid-pass");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        basic_stream(1'b1);

        $display("[TB] rotation and wrap");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        clear_counts();
        guard = 0;
        while (acc.size() < 6 * LW && guard < 400) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'b1, 1'b0);
            guard++;
        end
        checkOutput("rot_accepted", 72'(acc.size()), 72'(6 * LW));
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rot_done", 72'(done_cnt), 72'd4);
        checkOutput("rot_windows", 72'(win_cnt), 72'd24);
        checkOutput("rot_rdsel", 72'(dut.rd_sel), 72'd0);

        $display("[TB] simultaneous write and release");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 5 * LW; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        checkOutput("sim_accepted", 72'(acc.size()), 72'(5 * LW));
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("sim_done", 72'(done_cnt), 72'd3);
        checkOutput("sim_fill", 72'(dut.fill_count), 72'd16);

        $display("[TB] random traffic");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);

        $display("[TB] reset mid-pass");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3 * LW; i++) applyStimulus(1'b1, 8'(8'hc0 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("mid_rst_valid", 72'(window_valid), 72'd0);
        checkOutput("mid_rst_done", 72'(line_done), 72'd0);
        checkOutput("mid_rst_ready", 72'(pixel_in_ready), 72'd1);
        basic_stream(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
